// File: rtl/dbus_write_buffer.sv
// Posted-write buffer between the core data-bus master and the memory slave.
// Stores are absorbed into a small FIFO and drained in the background; loads
// that hit a buffered store are forwarded from the youngest matching entry,
// and load misses go to memory ahead of any pending drain.
module dbus_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic              s_read,
  input  logic              s_write,
  input  logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_read,
  output logic              m_write,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state_r, state_s;

  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  logic              m_read_r, m_write_r, m_read_s, m_write_s;
  logic [ADDR_W-1:0] m_addr_r, m_addr_s;
  logic [DATA_W-1:0] m_wdata_r, m_wdata_s;

  logic              full_s, empty_s, push_s, pop_s, read_req_s, hit_s;
  logic [DATA_W-1:0] hit_data_s;

  assign full_s     = (count_r == CNT_FULL);
  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign push_s     = s_write && !full_s;
  // A simultaneous store wins; the load is ignored for that cycle.
  assign read_req_s = s_read && !s_write;

  assign m_read  = m_read_r;
  assign m_write = m_write_r;
  assign m_addr  = m_addr_r;
  assign m_wdata = m_wdata_r;
  assign empty   = empty_s;

  // Forwarding search: walk oldest to youngest so the youngest word match wins.
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = {DATA_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < count_r) &&
          (addr_mem_r[rd_ptr_r + PTR_W'(k)][ADDR_W-1:2] == s_addr[ADDR_W-1:2])) begin
        hit_s      = 1'b1;
        hit_data_s = data_mem_r[rd_ptr_r + PTR_W'(k)];
      end else begin
        hit_s      = hit_s;
      end
    end
  end

  // Core-side completion and load data: stores, forwarded hits, memory reads.
  always_comb begin
    s_ready = 1'b0;
    s_rdata = hit_s ? hit_data_s : m_rdata;
    if (s_write) begin
      s_ready = !full_s;
    end else if (s_read && hit_s) begin
      s_ready = 1'b1;
    end else if (s_read && (state_r == ST_READ)) begin
      s_ready = m_ready;
    end else begin
      s_ready = 1'b0;
    end
  end

  // Next-state and next memory-port values; in-flight transfers hold until m_ready.
  always_comb begin
    state_s   = state_r;
    m_read_s  = m_read_r;
    m_write_s = m_write_r;
    m_addr_s  = m_addr_r;
    m_wdata_s = m_wdata_r;
    pop_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (read_req_s && !hit_s) begin
          state_s  = ST_READ;
          m_read_s = 1'b1;
          m_addr_s = s_addr;
        end else if (!empty_s) begin
          state_s   = ST_DRAIN;
          m_write_s = 1'b1;
          m_addr_s  = addr_mem_r[rd_ptr_r];
          m_wdata_s = data_mem_r[rd_ptr_r];
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (m_ready) begin
          state_s  = ST_IDLE;
          m_read_s = 1'b0;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (m_ready) begin
          state_s   = ST_IDLE;
          m_write_s = 1'b0;
          pop_s     = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        m_read_s  = 1'b0;
        m_write_s = 1'b0;
      end
    endcase
  end

  // Control state, memory-port registers, FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_r   <= ST_IDLE;
      m_read_r  <= 1'b0;
      m_write_r <= 1'b0;
      m_addr_r  <= {ADDR_W{1'b0}};
      m_wdata_r <= {DATA_W{1'b0}};
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_s;
      m_read_r  <= m_read_s;
      m_write_r <= m_write_s;
      m_addr_r  <= m_addr_s;
      m_wdata_r <= m_wdata_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents beyond count are don't-care, cleared for determinism.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= {ADDR_W{1'b0}};
        data_mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_s) begin
      addr_mem_r[wr_ptr_r] <= s_addr;
      data_mem_r[wr_ptr_r] <= s_wdata;
    end
  end

endmodule

// File: doc/dbus_write_buffer.md
# dbus_write_buffer

Posted-write buffer between the CPU core's data-bus master port and the memory slave. It absorbs stores into a small FIFO so the core never waits on store completion. Loads that hit a buffered store are forwarded from the youngest matching entry. Loads that miss go to memory with priority over draining.

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock, all state on rising edge
- res_n  in  1  asynchronous, active-low reset
- s_addr  in  ADDR_W  core request address
- s_read  in  1  core load request, held until s_ready
- s_write  in  1  core store request, held until s_ready
- s_wdata  in  DATA_W  core store data
- s_rdata  out  DATA_W  load data, valid when s_read && s_ready
- s_ready  out  1  combinational completion strobe to core
- m_addr  out  ADDR_W  memory address (registered)
- m_read  out  1  memory read strobe (registered)
- m_write  out  1  memory write strobe (registered)
- m_wdata  out  DATA_W  memory write data (registered)
- m_rdata  in  DATA_W  memory read data, valid when m_read && m_ready
- m_ready  in  1  memory completion strobe
- empty  out  1  FIFO holds no entries

## Operation
- Word granularity: match compares s_addr[ADDR_W-1:2]; addr[1:0] is carried unchanged to memory. No byte enables.
- Store: if count < DEPTH then s_ready=1 in the same cycle and the entry {addr,data} is pushed at the edge. If full, s_ready=0 until count drops.
  - Push and pop in the same edge: count unchanged.
  - No coalescing: a repeat address appends a new entry.
- Load hit, in any state: s_ready=1 the same cycle. s_rdata = data of the youngest valid entry whose word address matches. The head entry counts as valid until it is popped.
- Load miss: served through memory, s_rdata = m_rdata and s_ready = m_ready, but only in state READ.
- s_read && s_write together is illegal. The store takes precedence and the load is ignored that cycle.
- State machine:
  - IDLE → READ: s_read && !hit. Register m_read=1, m_addr=s_addr. Read misses have priority over draining.
  - IDLE → DRAIN: otherwise, if !empty. Register m_write=1 with the head addr and data.
  - READ → IDLE: on m_ready. Clear m_read.
  - DRAIN → IDLE: on m_ready. Pop the head and clear m_write.
  - READ and DRAIN hold every m_* output stable until m_ready. An in-flight transaction is never aborted.
- Reset (asynchronous, any state): count=0, pointers=0, state IDLE, m_read=0, m_write=0, m_addr=0, m_wdata=0, empty=1. Buffered stores are discarded.

## Timing
- Store accept: 0 cycles when not full.
- First drain: a store pushed at edge N (buffer idle and empty) gives m_write=1 from edge N+1.
- One IDLE bubble follows every completed memory transaction. Back-to-back drains issue m_write on every other cycle when memory is always ready.
- Load hit latency: 0 cycles.
- Load miss, memory always ready, buffer IDLE at request cycle C:
  - m_read is high from edge C+1.
  - s_ready=1 in cycle C+1.
- Load miss while DRAIN is in flight: the drain completes first, then one IDLE cycle, then the READ.
- Full: s_ready stays low for stores until the cycle after the pop edge.
- Pointers wrap modulo DEPTH. Full and empty are derived from a count of width log2(DEPTH)+1.
- Reset: all outputs reach their reset values asynchronously on res_n falling. The first transition out of IDLE is on the first rising edge after res_n is released.

## Test plan
- Reset with memory always ready, then store 0x11 to 0x40. Required:
  - s_ready high in the request cycle.
  - m_write with m_addr=0x40 and m_wdata=0x11 on the next cycle.
  - empty=1 after the pop.
- With m_ready held 0, store 0xA→0x40, 0xB→0x44, then 0xC→0x40, then load 0x42. Required:
  - s_ready=1 in the same cycle as the load.
  - s_rdata=0xC (youngest entry wins; addr[1:0] ignored).
- With m_ready held 0, issue DEPTH+1 stores. Required:
  - The 5th store (DEPTH=4) stalls.
  - When m_ready is raised it completes on the cycle after the first pop.
  - Memory sees all 5 writes in program order.
- With 2 stores buffered and the buffer in IDLE, load miss 0x100 (memory returns 0x55). Required:
  - m_read issues before any further m_write.
  - s_rdata=0x55.
  - Draining resumes afterwards.
- Hold m_ready=0 during DRAIN, then pulse res_n low. Required:
  - m_write drops immediately.
  - empty=1.
  - No write issues after release.
- Assert s_read and s_write together at 0x80. Required:
  - The store is accepted.
  - No m_read is issued.
